// File: rtl/matmul_instr_gen.sv
// Streams the MIPS instruction words that compute C = A x B for NxN matrices in data memory,
// one word per valid/ready handshake, walking elements row-major and the dot product over k.
module matmul_instr_gen #(
  parameter int N        = 3,
  parameter int A_BASE   = 0,
  parameter int B_BASE   = 9,
  parameter int C_BASE   = 18,
  parameter int BASE_REG = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  k
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB, S_MUL, S_ACC, S_ST, S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [4:0] BR   = 5'(BASE_REG);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  k_q, k_d;
  logic        fire;

  // The word shown in a state depends only on that state and the indices it is entered with.
  function automatic logic [31:0] encode(input state_t s, input logic [3:0] r,
                                         input logic [3:0] c, input logic [3:0] kk);
    logic [31:0] w;
    case (s)
      S_CLR:   w = {6'h08, BR, 5'd19, 16'd0};
      S_LDA:   w = {6'h23, BR, 5'd16, 16'(A_BASE + int'(r) * N + int'(kk))};
      S_LDB:   w = {6'h23, BR, 5'd17, 16'(B_BASE + int'(kk) * N + int'(c))};
      S_MUL:   w = {6'h00, 5'd16, 5'd17, 5'd18, 5'd0, 6'h18};
      S_ACC:   w = {6'h00, 5'd18, 5'd19, 5'd19, 5'd0, 6'h20};
      S_ST:    w = {6'h2B, BR, 5'd19, 16'(C_BASE + int'(r) * N + int'(c))};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign fire = valid_q && instr_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      S_CLR: if (fire) state_d = S_LDA;
      S_LDA: if (fire) state_d = S_LDB;
      S_LDB: if (fire) state_d = S_MUL;
      S_MUL: if (fire) state_d = S_ACC;
      S_ACC: begin
        if (fire) begin
          if (k_q == LAST) begin
            state_d = S_ST;
          end else begin
            state_d = S_LDA;
            k_d     = k_q + 4'd1;
          end
        end
      end
      S_ST: begin
        if (fire) begin
          k_d = '0;
          if (row_q == LAST && col_q == LAST) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = S_CLR;
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Under backpressure every _d equals its _q, so the held word is re-encoded unchanged.
    instr_d = encode(state_d, row_d, col_d, k_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign row         = row_q;
  assign col         = col_q;
  assign k           = k_q;

endmodule

// File: tb/tb_matmul_instr_gen.sv
// Directed bench for matmul_instr_gen: N=3 and N=2 instances, streams compared against a
// loop-built reference sequence plus hand-computed words.
module tb_matmul_instr_gen;

  logic clk = 1'b0;
  logic rst, start, instr_ready;
  logic sel2;

  logic        valid3, busy3, done3, valid2, busy2, done2;
  logic [31:0] instr3, instr2;
  logic [3:0]  row3, col3, k3, row2, col2, k2;

  logic        valid_m, busy_m, done_m;
  logic [31:0] instr_m;
  logic [3:0]  row_m, col_m, k_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  matmul_instr_gen #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .instr_ready(instr_ready),
    .instr_valid(valid3), .instr(instr3), .busy(busy3), .done(done3),
    .row(row3), .col(col3), .k(k3)
  );

  matmul_instr_gen #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .instr_ready(instr_ready),
    .instr_valid(valid2), .instr(instr2), .busy(busy2), .done(done2),
    .row(row2), .col(col2), .k(k2)
  );

  assign valid_m = sel2 ? valid2 : valid3;
  assign busy_m  = sel2 ? busy2  : busy3;
  assign done_m  = sel2 ? done2  : done3;
  assign instr_m = sel2 ? instr2 : instr3;
  assign row_m   = sel2 ? row2   : row3;
  assign col_m   = sel2 ? col2   : col3;
  assign k_m     = sel2 ? k2     : k3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference stream from the plain triple loop over i, j, k.
  task automatic build(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        exp_q.push_back({6'h08, 5'd23, 5'd19, 16'd0});
        for (int kk = 0; kk < n; kk++) begin
          exp_q.push_back({6'h23, 5'd23, 5'd16, 16'(i * n + kk)});
          exp_q.push_back({6'h23, 5'd23, 5'd17, 16'(9 + kk * n + j)});
          exp_q.push_back(32'h02119018);
          exp_q.push_back(32'h02539820);
        end
        exp_q.push_back({6'h2B, 5'd23, 5'd19, 16'(18 + i * n + j)});
      end
  endtask

  // Leaves the bench at posedge+1 of the cycle in which the start was accepted.
  task automatic do_start();
    instr_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    int sw_idx;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    sw_idx = 0;
    foreach (got_q[i]) begin
      if (got_q[i][31:26] == 6'h2B) begin
        check($sformatf("%s_sw%0d", tag, sw_idx), 32'(got_q[i][15:0]), 32'(18 + sw_idx));
        sw_idx++;
      end
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: 5-cycle stall at word 7,
  // 3: start pulse mid-run, 4: reset after 40 transfers.
  task automatic collect(input string tag, input int mode);
    int xfer, stall, cyc, last_cyc, done_cyc, done_cnt, post;
    bit busy_bad, fin;
    xfer = 0; stall = 5; cyc = 0; last_cyc = -1; done_cyc = -1; done_cnt = 0; post = 0;
    busy_bad = 1'b0; fin = 1'b0;
    got_q.delete();
    while (!fin) begin
      start = 1'b0;
      case (mode)
        1:       instr_ready = 1'($urandom_range(0, 1));
        2:       instr_ready = !(xfer == 6 && stall > 0);
        3: begin instr_ready = 1'b1; start = (xfer == 20); end
        default: instr_ready = 1'b1;
      endcase
      if (mode == 4 && xfer == 40) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_valid"}, 32'(valid_m), 32'd0);
        check({tag, "_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_rck"}, 32'({row_m, col_m, k_m}), 32'd0);
        check({tag, "_count"}, 32'(got_q.size()), 32'd40);
        return;
      end
      @(negedge clk);
      if (mode == 2 && xfer == 6 && stall > 0) begin
        check($sformatf("%s_hold_instr%0d", tag, stall), instr_m, 32'h8EF1000C);
        check($sformatf("%s_hold_rck%0d", tag, stall), 32'({row_m, col_m, k_m}), 32'h001);
        stall--;
      end
      if (valid_m && instr_ready) begin
        got_q.push_back(instr_m);
        xfer++;
        last_cyc = cyc;
      end
      if (done_m) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt == 0 && !busy_m) busy_bad = 1'b1;
      if (done_cnt > 0) post++;
      if (post >= 4 || cyc >= 3000) fin = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_delay"}, 32'(done_cyc - last_cyc), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
    check({tag, "_idle_valid"}, 32'(valid_m), 32'd0);
    compare_stream(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; sel2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, with start asserted alongside reset to show reset wins.
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_instr", instr_m, 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_rck", 32'({row_m, col_m, k_m}), 32'd0);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_over_start", 32'(busy_m), 32'd0);

    // T1/T2: full run with ready held high.
    build(3);
    do_start();
    check("t1_valid", 32'(valid_m), 32'd1);
    check("t1_busy", 32'(busy_m), 32'd1);
    check("t1_first", instr_m, 32'h22F30000);
    collect("t2", 0);
    check("t1_w0", got_q[0], 32'h22F30000);
    check("t1_w1", got_q[1], 32'h8EF00000);
    check("t1_w2", got_q[2], 32'h8EF10009);
    check("t1_w3", got_q[3], 32'h02119018);
    check("t1_w4", got_q[4], 32'h02539820);
    check("t1_w5", got_q[5], 32'h8EF00001);
    check("t1_w13", got_q[13], 32'hAEF30012);
    check("t2_last", got_q[125], 32'hAEF3001A);

    // T3: backpressure on the seventh word.
    do_start();
    collect("t3", 2);
    check("t3_resume", got_q[7], 32'h02119018);

    // T4: random ready.
    do_start();
    collect("t4", 1);

    // T5: start pulse while busy, then reset mid-run and restart.
    do_start();
    collect("t5a", 3);
    do_start();
    collect("t5b", 4);
    do_start();
    check("t5_restart", instr_m, 32'h22F30000);
    collect("t5c", 0);

    // T6: N=2 instance.
    sel2 = 1'b1;
    build(2);
    do_start();
    collect("t6", 0);
    check("t6_ldb0", got_q[2], 32'h8EF10009);
    check("t6_ldb1", got_q[6], 32'h8EF1000B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
